// File: rtl/color_lut_pkg.sv
// Shared types and constants for the colour LUT runtime loader.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package color_lut_pkg;

  // Loader phases; DONE and ERROR hold their status flag until the next start.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Width of the running modular sums.
  localparam int CHK_WIDTH = 16;

  // Table depth from address width.
  function automatic int lut_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int LUT_DEPTH = lut_depth(11);

endpackage

// File: rtl/lut_sum16.sv
// Clear/accumulate modular adder for the table checksums.
// One cycle: an add presented at cycle n is visible in sum at n+1.
// No backpressure; accumulates whenever add is high, clr has priority.
module lut_sum16
  import color_lut_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 add,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [CHK_WIDTH-1:0] sum
);

  // Running sum wraps naturally at 2**CHK_WIDTH; input is zero-extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + CHK_WIDTH'(din);
    end
  end

endmodule

// File: rtl/color_lut_writer.sv
// Streams a full colour LUT into a simple-dual-port RAM, then reads it back and checks the sum.
// Write path one cycle (accepted byte -> wr_en next cycle); verify takes depth + RD_LATENCY + 1 cycles.
// s_ready is high for the whole LOAD phase only; a start pulse while busy is ignored.
module color_lut_writer
  import color_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CHK_WIDTH-1:0]  checksum
);

  localparam int DEPTH = lut_depth(ADDR_WIDTH);
  // Verify cycle counter must reach DEPTH + RD_LATENCY.
  localparam int VCW = ADDR_WIDTH + 2;
  localparam logic [VCW-1:0]        V_ISSUE_END = VCW'(DEPTH);
  localparam logic [VCW-1:0]        V_CMP       = VCW'(DEPTH + RD_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] W_LAST      = '1;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  wr_cnt;
  logic [VCW-1:0]         v_cnt;
  logic [RD_LATENCY-1:0]  vld_sr;
  logic                   xfer;
  logic                   load_entry;
  logic                   issue;
  logic                   cmp;
  logic                   rd_vld;
  logic [CHK_WIDTH-1:0]   wr_sum;
  logic [CHK_WIDTH-1:0]   rd_sum;

  // Verify phase bookkeeping: reads are issued for the first DEPTH cycles,
  // the compare happens once the last read has come back through the pipe.
  assign issue  = (state == ST_VERIFY) && (v_cnt < V_ISSUE_END);
  assign cmp    = (state == ST_VERIFY) && (v_cnt == V_CMP);
  assign rd_vld = (state == ST_VERIFY) && vld_sr[RD_LATENCY-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs (status flags track the state directly).
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    xfer       = 1'b0;
    load_entry = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done = (state == ST_DONE);
        err  = (state == ST_ERROR);
        if (start) begin
          state_nxt  = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        xfer    = s_valid;
        if (s_valid && (wr_cnt == W_LAST)) begin
          state_nxt = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        busy = 1'b1;
        if (cmp) begin
          state_nxt = (wr_sum == rd_sum) ? ST_DONE : ST_ERROR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Load address counter and the registered RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (load_entry) begin
        wr_cnt <= '0;
      end else if (xfer) begin
        wr_cnt  <= wr_cnt + 1'b1;
        wr_addr <= wr_cnt;
        wr_data <= s_data;
      end
    end
  end

  // Readback sequencing: read address stepping, phase cycle count and the
  // valid tag pipe that lines up with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_cnt   <= '0;
      rd_addr <= '0;
      vld_sr  <= '0;
    end else if (load_entry) begin
      v_cnt   <= '0;
      rd_addr <= '0;
      vld_sr  <= '0;
    end else if (state == ST_VERIFY) begin
      v_cnt     <= v_cnt + 1'b1;
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      if (issue) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  lut_sum16 #(
    .IN_WIDTH (DATA_WIDTH)
  ) u_wr_sum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_entry),
    .add   (xfer),
    .din   (s_data),
    .sum   (wr_sum)
  );

  lut_sum16 #(
    .IN_WIDTH (DATA_WIDTH)
  ) u_rd_sum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_entry),
    .add   (rd_vld),
    .din   (rd_data),
    .sum   (rd_sum)
  );

  assign checksum = wr_sum;

endmodule
